// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (F) and data access (D).
// Fixed-latency access: grant edge, MEM_LAT cycles of mem_en, then a one-cycle ack.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                gnt_d_q, gnt_d_d;
  logic                last_d_q, last_d_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic any_req;
  logic pick_d;
  logic last_beat;

  assign any_req   = f_req | d_req;
  // On a tie, the requester that did not win last time gets the port.
  assign pick_d    = d_req & (~f_req | ~last_d_q);
  assign last_beat = (cnt_q == 3'd1);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)   state_d = ACCESS;
      ACCESS:  if (last_beat) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Captured transaction and returned read data
  always_comb begin
    cnt_d     = cnt_q;
    gnt_d_d   = gnt_d_q;
    last_d_d  = last_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          we_d     = pick_d & d_we;
          addr_d   = pick_d ? d_addr : f_addr;
          wdata_d  = pick_d ? d_wdata : '0;
          cnt_d    = LAT;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (last_beat && !we_q) begin
          if (gnt_d_q) d_rdata_d = mem_rdata;
          else         f_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      last_d_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      gnt_d_q   <= gnt_d_d;
      last_d_q  <= last_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs decode only registered state, so requests never reach mem_* combinationally.
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    f_ack     = (state_q == DONE) & ~gnt_d_q;
    d_ack     = (state_q == DONE) & gnt_d_q;
    busy      = (state_q != IDLE);
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2: vector table plus reset/round-robin/drop sequences.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_ack, d_ack, mem_en, mem_we, busy;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] rdata;
    logic        exp_d;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic [15:0] exp_f_rdata;
    logic [15:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Order matters: last grant and read-data registers carry over between rows.
    vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hABCD,
                1'b0, 16'h0010, 1'b0, 16'h0000, 16'hABCD, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 16'h9999,
                1'b1, 16'h0020, 1'b1, 16'h1234, 16'hABCD, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555,
                1'b1, 16'h0030, 1'b0, 16'h0000, 16'hABCD, 16'h5555};
    vecs[3] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0050, 16'h0000, 16'h1111,
                1'b0, 16'h0040, 1'b0, 16'h0000, 16'h1111, 16'h5555};
    vecs[4] = '{1'b1, 16'h0060, 1'b1, 1'b1, 16'h0070, 16'hBEEF, 16'h8888,
                1'b1, 16'h0070, 1'b1, 16'hBEEF, 16'h1111, 16'h5555};
    vecs[5] = '{1'b1, 16'h0080, 1'b1, 1'b0, 16'h0090, 16'h0000, 16'h2222,
                1'b0, 16'h0080, 1'b0, 16'h0000, 16'h2222, 16'h5555};
    vecs[6] = '{1'b1, 16'h00A0, 1'b0, 1'b1, 16'h00A4, 16'hCAFE, 16'h3333,
                1'b0, 16'h00A0, 1'b0, 16'h0000, 16'h3333, 16'h5555};
    vecs[7] = '{1'b1, 16'h00B0, 1'b1, 1'b0, 16'h00C0, 16'h0000, 16'h4444,
                1'b1, 16'h00C0, 1'b0, 16'h0000, 16'h3333, 16'h4444};

    // Reset with random inputs
    RST_N     = 1'b0;
    f_req     = 1'($urandom);
    d_req     = 1'($urandom);
    d_we      = 1'($urandom);
    f_addr    = 16'($urandom);
    d_addr    = 16'($urandom);
    d_wdata   = 16'($urandom);
    mem_rdata = 16'($urandom);
    repeat (3) tick();
    check("rst_outputs", {f_ack, d_ack, mem_en, mem_we, busy}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", {f_rdata, d_rdata}, 32'h0);
    f_req = 1'b0;
    d_req = 1'b0;
    RST_N = 1'b1;
    tick();
    check("idle_after_release", busy, 32'h0);

    for (int i = 0; i < 8; i++) begin
      f_req     = vecs[i].f_req;
      f_addr    = vecs[i].f_addr;
      d_req     = vecs[i].d_req;
      d_we      = vecs[i].d_we;
      d_addr    = vecs[i].d_addr;
      d_wdata   = vecs[i].d_wdata;
      mem_rdata = ~vecs[i].rdata;
      tick();
      check($sformatf("v%0d_access1", i), {busy, mem_en, mem_we, f_ack, d_ack},
            {27'h0, 1'b1, 1'b1, vecs[i].exp_we, 2'b00});
      check($sformatf("v%0d_addr1", i), mem_addr, 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_wdata1", i), mem_wdata, 32'(vecs[i].exp_wdata));
      // Inputs moving after the grant must not disturb the access.
      f_addr    = ~f_addr;
      d_addr    = ~d_addr;
      d_wdata   = ~d_wdata;
      d_we      = ~d_we;
      mem_rdata = vecs[i].rdata;
      tick();
      check($sformatf("v%0d_access2", i), {mem_en, mem_we, f_ack, d_ack},
            {28'h0, 1'b1, vecs[i].exp_we, 2'b00});
      check($sformatf("v%0d_addr2", i), mem_addr, 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_wdata2", i), mem_wdata, 32'(vecs[i].exp_wdata));
      tick();
      check($sformatf("v%0d_ack", i), {mem_en, f_ack, d_ack, busy},
            {28'h0, 1'b0, ~vecs[i].exp_d, vecs[i].exp_d, 1'b1});
      check($sformatf("v%0d_f_rdata", i), f_rdata, 32'(vecs[i].exp_f_rdata));
      check($sformatf("v%0d_d_rdata", i), d_rdata, 32'(vecs[i].exp_d_rdata));
      f_req = 1'b0;
      d_req = 1'b0;
      tick();
      check($sformatf("v%0d_idle", i), {f_ack, d_ack, busy, mem_en}, 32'h0);
    end

    // Reset in the middle of an access aborts it.
    f_req     = 1'b1;
    f_addr    = 16'h00D0;
    d_we      = 1'b0;
    mem_rdata = 16'hEEEE;
    tick();
    check("abort_pre_mem_en", mem_en, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check("abort_async", {mem_en, busy, f_ack, d_ack}, 32'h0);
    check("abort_rdata", {f_rdata, d_rdata}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_noack%0d", i), {f_ack, d_ack, mem_en}, 32'h0);
    end

    // Both requests held after release: F first, then strict alternation.
    d_req     = 1'b1;
    d_addr    = 16'h00E4;
    mem_rdata = 16'h7777;
    RST_N     = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("rr_f_ack%0d", i), f_ack, 32'((i % 4 == 3) && ((i / 4) % 2 == 0)));
      check($sformatf("rr_d_ack%0d", i), d_ack, 32'((i % 4 == 3) && ((i / 4) % 2 == 1)));
      if (i == 3) check("rr_f_rdata", f_rdata, 32'h7777);
      if (i == 7) check("rr_d_rdata", d_rdata, 32'h7777);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    tick();
    check("rr_idle", busy, 32'h0);

    // Data read whose request drops right after the grant still completes.
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 16'h00F0;
    mem_rdata = 16'h6666;
    tick();
    d_req = 1'b0;
    check("drop_access", {mem_en, mem_we}, 32'h2);
    check("drop_addr", mem_addr, 32'h00F0);
    tick();
    check("drop_access2", mem_en, 32'h1);
    tick();
    check("drop_ack", {f_ack, d_ack}, 32'h1);
    check("drop_d_rdata", d_rdata, 32'h6666);
    tick();
    check("drop_idle", {d_ack, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
